// File: rtl/multicycle_ctlpath_fsm.sv
// Control FSM for the multicycle RV32I core: FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
// Define RVSIMPLE_MC_PERF_COUNTERS_EN to add retired/stall counters.
module multicycle_ctlpath_fsm #(
  parameter logic [2:0] RESET_STATE = 3'd0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] inst_opcode,
  input  logic       take_branch,
  input  logic       mem_ready,
  output logic       pc_write_enable,
  output logic       ir_write_enable,
  output logic       regfile_write_enable,
  output logic       alu_operand_a_select,
  output logic [1:0] alu_operand_b_select,
  output logic [1:0] alu_op_type,
  output logic       mem_read_enable,
  output logic       mem_write_enable,
  output logic       mem_address_select,
  output logic [2:0] reg_writeback_select,
  output logic [1:0] next_pc_select,
  output logic       illegal_inst,
  output logic [2:0] fsm_state
`ifdef RVSIMPLE_MC_PERF_COUNTERS_EN
  ,
  output logic [31:0] retired_count,
  output logic [31:0] stall_count
`endif
);

  localparam logic [2:0] ST_FETCH     = 3'd0;
  localparam logic [2:0] ST_DECODE    = 3'd1;
  localparam logic [2:0] ST_EXECUTE   = 3'd2;
  localparam logic [2:0] ST_MEM       = 3'd3;
  localparam logic [2:0] ST_WRITEBACK = 3'd4;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  logic is_load, is_store, is_op_imm, is_op;
  logic is_branch, is_jal, is_jalr, is_lui;
  logic is_auipc, is_nop, is_legal;

  assign is_load   = (inst_opcode == OPC_LOAD);
  assign is_store  = (inst_opcode == OPC_STORE);
  assign is_op_imm = (inst_opcode == OPC_OP_IMM);
  assign is_op     = (inst_opcode == OPC_OP);
  assign is_branch = (inst_opcode == OPC_BRANCH);
  assign is_jal    = (inst_opcode == OPC_JAL);
  assign is_jalr   = (inst_opcode == OPC_JALR);
  assign is_lui    = (inst_opcode == OPC_LUI);
  assign is_auipc  = (inst_opcode == OPC_AUIPC);
  assign is_nop    = (inst_opcode == OPC_MISC_MEM)
                   | (inst_opcode == OPC_SYSTEM);
  assign is_legal  = is_load | is_store | is_op_imm | is_op
                   | is_branch | is_jal | is_jalr | is_lui
                   | is_auipc | is_nop;

  logic [2:0] state_q, state_d;

  always_ff @(posedge clock) begin
    if (reset) state_q <= RESET_STATE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = ST_FETCH;
    unique case (state_q)
      ST_FETCH:
        state_d = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE:
        state_d = is_legal ? ST_EXECUTE : ST_FETCH;
      ST_EXECUTE: begin
        unique case (1'b1)
          is_load, is_store:
            state_d = ST_MEM;
          is_op_imm, is_op, is_auipc,
          is_lui, is_jal, is_jalr:
            state_d = ST_WRITEBACK;
          default:
            state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (!mem_ready)   state_d = ST_MEM;
        else if (is_load) state_d = ST_WRITEBACK;
        else              state_d = ST_FETCH;
      end
      ST_WRITEBACK:
        state_d = ST_FETCH;
      default:
        state_d = ST_FETCH;
    endcase
  end

  // Reset forces every control output low so nothing commits that cycle.
  always_comb begin
    pc_write_enable      = 1'b0;
    ir_write_enable      = 1'b0;
    regfile_write_enable = 1'b0;
    alu_operand_a_select = 1'b0;
    alu_operand_b_select = 2'd0;
    alu_op_type          = 2'd0;
    mem_read_enable      = 1'b0;
    mem_write_enable     = 1'b0;
    mem_address_select   = 1'b0;
    reg_writeback_select = 3'd0;
    next_pc_select       = 2'd0;
    illegal_inst         = 1'b0;
    if (!reset) begin
      unique case (state_q)
        ST_FETCH: begin
          mem_read_enable = 1'b1;
          ir_write_enable = mem_ready;
        end
        ST_DECODE: begin
          illegal_inst    = !is_legal;
          pc_write_enable = !is_legal;
        end
        ST_EXECUTE: begin
          unique case (1'b1)
            is_load, is_store: begin
              alu_operand_b_select = 2'd1;
            end
            is_op_imm: begin
              alu_operand_b_select = 2'd1;
              alu_op_type          = 2'd1;
            end
            is_op: begin
              alu_op_type = 2'd2;
            end
            is_auipc: begin
              alu_operand_a_select = 1'b1;
              alu_operand_b_select = 2'd1;
            end
            is_lui, is_jal, is_jalr: begin
            end
            is_branch: begin
              alu_op_type     = 2'd3;
              pc_write_enable = 1'b1;
              next_pc_select  = take_branch ? 2'd1 : 2'd0;
            end
            default: begin
              pc_write_enable = 1'b1;
            end
          endcase
        end
        ST_MEM: begin
          mem_address_select = 1'b1;
          mem_read_enable    = is_load;
          mem_write_enable   = is_store;
          pc_write_enable    = mem_ready && !is_load;
        end
        ST_WRITEBACK: begin
          regfile_write_enable = 1'b1;
          pc_write_enable      = 1'b1;
          unique case (1'b1)
            is_load:          reg_writeback_select = 3'd1;
            is_jal, is_jalr:  reg_writeback_select = 3'd2;
            is_lui:           reg_writeback_select = 3'd3;
            default:          reg_writeback_select = 3'd0;
          endcase
          unique case (1'b1)
            is_jal:   next_pc_select = 2'd2;
            is_jalr:  next_pc_select = 2'd3;
            default:  next_pc_select = 2'd0;
          endcase
        end
        default: begin
        end
      endcase
    end
  end

  assign fsm_state = reset ? 3'd0 : state_q;

`ifdef RVSIMPLE_MC_PERF_COUNTERS_EN
  logic [31:0] retired_q, retired_d;
  logic [31:0] stall_q, stall_d;
  logic        stalled;

  always_comb begin
    stalled   = ((state_q == ST_FETCH) || (state_q == ST_MEM))
              && !mem_ready;
    retired_d = retired_q + {31'd0, pc_write_enable};
    stall_d   = stall_q + {31'd0, stalled};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      retired_q <= 32'd0;
      stall_q   <= 32'd0;
    end else begin
      retired_q <= retired_d;
      stall_q   <= stall_d;
    end
  end

  assign retired_count = retired_q;
  assign stall_count   = stall_q;
`endif

endmodule

// File: tb/tb_multicycle_ctlpath_fsm.sv
// Bench for multicycle_ctlpath_fsm: vector table, reset sequence and
// randomized instructions checked against a per-instruction model.
module tb_multicycle_ctlpath_fsm;

  logic       clock, reset;
  logic [6:0] inst_opcode;
  logic       take_branch, mem_ready;
  logic       pc_write_enable, ir_write_enable, regfile_write_enable;
  logic       alu_operand_a_select;
  logic [1:0] alu_operand_b_select, alu_op_type;
  logic       mem_read_enable, mem_write_enable, mem_address_select;
  logic [2:0] reg_writeback_select;
  logic [1:0] next_pc_select;
  logic       illegal_inst;
  logic [2:0] fsm_state;
`ifdef RVSIMPLE_MC_PERF_COUNTERS_EN
  logic [31:0] retired_count, stall_count;
`endif

  multicycle_ctlpath_fsm dut (
    .clock                (clock),
    .reset                (reset),
    .inst_opcode          (inst_opcode),
    .take_branch          (take_branch),
    .mem_ready            (mem_ready),
    .pc_write_enable      (pc_write_enable),
    .ir_write_enable      (ir_write_enable),
    .regfile_write_enable (regfile_write_enable),
    .alu_operand_a_select (alu_operand_a_select),
    .alu_operand_b_select (alu_operand_b_select),
    .alu_op_type          (alu_op_type),
    .mem_read_enable      (mem_read_enable),
    .mem_write_enable     (mem_write_enable),
    .mem_address_select   (mem_address_select),
    .reg_writeback_select (reg_writeback_select),
    .next_pc_select       (next_pc_select),
    .illegal_inst         (illegal_inst),
    .fsm_state            (fsm_state)
`ifdef RVSIMPLE_MC_PERF_COUNTERS_EN
    ,
    .retired_count        (retired_count),
    .stall_count          (stall_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // sel = {a_sel, b_sel, alu_op} as seen in the EXECUTE cycle
  typedef struct {
    logic [6:0] op;
    bit         tb;
    int nf; int nm; int cyc; int npc; int wb;
    int rf; int ill; int sel; int rd; int wr; int as_;
  } vec_t;

  typedef struct {
    int cyc; int pcw; int irw; int rfw; int ill;
    int rd; int wr; int as_; int both;
    int npc; int wb; int sel; int dec;
  } obs_t;

  int n_pass, n_total;
  int exp_ret, exp_stall;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic bit legal_op(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011,
      7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
      7'b0010111, 7'b0001111, 7'b1110011: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic vec_t model(input logic [6:0] op, input bit tb,
                                 input int nf, input int nm);
    vec_t v;
    bit ld, st, br, nop, jal, jalr, lui, auipc, opi, opr, ill;
    ld    = (op == 7'b0000011);
    st    = (op == 7'b0100011);
    opi   = (op == 7'b0010011);
    opr   = (op == 7'b0110011);
    br    = (op == 7'b1100011);
    jal   = (op == 7'b1101111);
    jalr  = (op == 7'b1100111);
    lui   = (op == 7'b0110111);
    auipc = (op == 7'b0010111);
    nop   = (op == 7'b0001111) || (op == 7'b1110011);
    ill   = !legal_op(op);
    if (!(ld || st)) nm = 0;
    v = '{default: 0};
    v.op = op; v.tb = tb; v.nf = nf; v.nm = nm;
    if (ill)             v.cyc = 2;
    else if (br || nop)  v.cyc = 3;
    else if (ld)         v.cyc = 5;
    else                 v.cyc = 4;
    v.cyc += nf + nm;
    v.npc = br ? int'(tb) : jal ? 2 : jalr ? 3 : 0;
    v.rf  = (ill || br || st || nop) ? 0 : 1;
    v.wb  = ld ? 1 : (jal || jalr) ? 2 : lui ? 3 : 0;
    v.ill = ill ? 1 : 0;
    v.sel = (ld || st) ? 4 : opi ? 5 : opr ? 2 :
            auipc ? 20 : br ? 3 : 0;
    v.rd  = nf + 1 + (ld ? nm + 1 : 0);
    v.wr  = st ? nm + 1 : 0;
    v.as_ = (ld || st) ? nm + 1 : 0;
    return v;
  endfunction

  // Starts just after a rising edge with the FSM in FETCH.
  task automatic run_instr(input vec_t v, output obs_t o);
    bit done;
    int mem_lo;
    o = '{default: 0};
    inst_opcode = v.op;
    take_branch = v.tb;
    done = 1'b0;
    mem_lo = v.nf + 3;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c < v.nf)
        mem_ready = 1'b0;
      else if (c == v.nf)
        mem_ready = 1'b1;
      else if (v.as_ > 0 && c >= mem_lo && c < mem_lo + v.nm)
        mem_ready = 1'b0;
      else if (v.as_ > 0 && c == mem_lo + v.nm)
        mem_ready = 1'b1;
      else
        mem_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
      o.cyc++;
      o.pcw  += int'(pc_write_enable);
      o.irw  += int'(ir_write_enable);
      o.rfw  += int'(regfile_write_enable);
      o.ill  += int'(illegal_inst);
      o.rd   += int'(mem_read_enable);
      o.wr   += int'(mem_write_enable);
      o.as_  += int'(mem_address_select);
      o.both += int'(mem_read_enable && mem_write_enable);
      if (c == v.nf + 1) o.dec = int'(fsm_state);
      if (c == v.nf + 2)
        o.sel = int'({alu_operand_a_select,
                      alu_operand_b_select, alu_op_type});
      if (regfile_write_enable) o.wb = int'(reg_writeback_select);
      if (pc_write_enable) begin
        o.npc = int'(next_pc_select);
        done = 1'b1;
      end
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_instr(input string tag, input vec_t v);
    obs_t o;
    run_instr(v, o);
    chk({tag, ".cycles"}, o.cyc, v.cyc);
    chk({tag, ".pc_we"}, o.pcw, 1);
    chk({tag, ".ir_we"}, o.irw, 1);
    chk({tag, ".rf_we"}, o.rfw, v.rf);
    chk({tag, ".illegal"}, o.ill, v.ill);
    chk({tag, ".mem_rd"}, o.rd, v.rd);
    chk({tag, ".mem_wr"}, o.wr, v.wr);
    chk({tag, ".addr_sel"}, o.as_, v.as_);
    chk({tag, ".rd_and_wr"}, o.both, 0);
    chk({tag, ".next_pc"}, o.npc, v.npc);
    chk({tag, ".wb_sel"}, o.wb, v.wb);
    chk({tag, ".alu_sel"}, o.sel, v.sel);
    chk({tag, ".decode_state"}, o.dec, 1);
`ifdef RVSIMPLE_MC_PERF_COUNTERS_EN
    exp_ret++;
    exp_stall += v.nf + v.nm;
    chk({tag, ".retired"}, int'(retired_count), exp_ret);
    chk({tag, ".stalls"}, int'(stall_count), exp_stall);
`endif
  endtask

  function automatic int all_outs();
    return int'({pc_write_enable, ir_write_enable,
                 regfile_write_enable, alu_operand_a_select,
                 alu_operand_b_select, alu_op_type,
                 mem_read_enable, mem_write_enable,
                 mem_address_select, reg_writeback_select,
                 next_pc_select, illegal_inst});
  endfunction

  vec_t tbl[14];
  logic [6:0] legal_ops[11];

  initial begin
    tbl[0]  = '{7'b0110011, 0, 0, 0, 4, 0, 0, 1, 0, 2, 1, 0, 0};
    tbl[1]  = '{7'b0000011, 0, 0, 2, 7, 0, 1, 1, 0, 4, 4, 0, 3};
    tbl[2]  = '{7'b1100011, 1, 0, 0, 3, 1, 0, 0, 0, 3, 1, 0, 0};
    tbl[3]  = '{7'b1100011, 0, 0, 0, 3, 0, 0, 0, 0, 3, 1, 0, 0};
    tbl[4]  = '{7'b1100111, 0, 0, 0, 4, 3, 2, 1, 0, 0, 1, 0, 0};
    tbl[5]  = '{7'b0100011, 0, 1, 1, 6, 0, 0, 0, 0, 4, 2, 2, 2};
    tbl[6]  = '{7'b1111111, 0, 0, 0, 2, 0, 0, 0, 1, 0, 1, 0, 0};
    tbl[7]  = '{7'b1101111, 0, 0, 0, 4, 2, 2, 1, 0, 0, 1, 0, 0};
    tbl[8]  = '{7'b0110111, 0, 0, 0, 4, 0, 3, 1, 0, 0, 1, 0, 0};
    tbl[9]  = '{7'b0010111, 0, 0, 0, 4, 0, 0, 1, 0, 20, 1, 0, 0};
    tbl[10] = '{7'b0010011, 0, 2, 0, 6, 0, 0, 1, 0, 5, 3, 0, 0};
    tbl[11] = '{7'b1110011, 0, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[12] = '{7'b0001111, 0, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[13] = '{7'b0100011, 0, 0, 0, 4, 0, 0, 0, 0, 4, 1, 1, 1};
    legal_ops = '{7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011,
                  7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                  7'b0010111, 7'b0001111, 7'b1110011};
    n_pass = 0; n_total = 0;
    exp_ret = 0; exp_stall = 0;

    reset = 1'b1;
    inst_opcode = 7'b0110011;
    take_branch = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk("reset.outs", all_outs(), 0);
      chk("reset.state", int'(fsm_state), 0);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    @(negedge clock);
    chk("pre_reset.exec_alu_op", int'(alu_op_type), 2);
    chk("pre_reset.exec_state", int'(fsm_state), 2);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mid_reset.outs", all_outs(), 0);
      chk("mid_reset.state", int'(fsm_state), 0);
      @(posedge clock); #1;
    end
    reset = 1'b0;
    #1;
    chk("post_reset.state", int'(fsm_state), 0);
    chk("post_reset.mem_rd", int'(mem_read_enable), 1);
`ifdef RVSIMPLE_MC_PERF_COUNTERS_EN
    chk("post_reset.retired", int'(retired_count), 0);
`endif

    for (int i = 0; i < 14; i++)
      check_instr($sformatf("vec%0d", i), tbl[i]);

    for (int i = 0; i < 60; i++) begin
      logic [6:0] op;
      if ($urandom_range(0, 4) == 0) begin
        op = 7'($urandom_range(0, 127));
        while (legal_op(op)) op = 7'($urandom_range(0, 127));
      end else begin
        op = legal_ops[$urandom_range(0, 10)];
      end
      check_instr($sformatf("rnd%0d", i),
                  model(op, 1'($urandom_range(0, 1)),
                        int'($urandom_range(0, 2)),
                        int'($urandom_range(0, 3))));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_ctlpath_fsm.md
Name: multicycle_ctlpath_fsm

Overview:
Control FSM for the multicycle variant of the RV32I core. It sequences one shared ALU, the instruction register and a unified memory port across FETCH/DECODE/EXECUTE/MEM/WRITEBACK cycles. It drives all datapath enables and selects from the IR opcode, the branch decision and a memory ready handshake. It replaces the single-cycle control path when the core is built multicycle.

Parameters:
RESET_STATE, 3'd0, state entered on reset (FETCH); fixed, not overridden in normal builds.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
inst_opcode  in  7  opcode field from the instruction register (stable after FETCH)
take_branch  in  1  branch condition from control_transfer, valid in EXECUTE
mem_ready  in  1  memory completes the current read/write this cycle
pc_write_enable  out  1  PC register load
ir_write_enable  out  1  instruction register load
regfile_write_enable  out  1  register file write
alu_operand_a_select  out  1  0=rs1, 1=PC
alu_operand_b_select  out  2  0=rs2, 1=immediate, 2=constant 4
alu_op_type  out  2  0=ADD, 1=OP_IMM funct decode, 2=OP funct decode, 3=branch compare
mem_read_enable  out  1  memory read request
mem_write_enable  out  1  memory write request
mem_address_select  out  1  0=PC, 1=ALU output register
reg_writeback_select  out  3  0=ALU, 1=load data, 2=PC+4, 3=immediate (LUI)
next_pc_select  out  2  0=PC+4, 1=branch target, 2=JAL target, 3=JALR target
illegal_inst  out  1  one-cycle pulse on an unrecognised opcode
fsm_state  out  3  current state, for debug

Behaviour:
- States: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4. Codes 5-7 are unreachable; if entered, go to FETCH next cycle with all outputs 0.
- Outputs are combinational from state, opcode, take_branch and mem_ready. The state register updates on the rising clock edge.
- Reset: while reset=1, all outputs are 0 and fsm_state is 0. State becomes FETCH. Reset mid-instruction abandons the instruction with no PC, IR, regfile or memory write in that cycle.
- FETCH: mem_read_enable=1, mem_address_select=0. Hold while mem_ready=0. When mem_ready=1: ir_write_enable=1, go to DECODE.
- DECODE: no enables asserted (register operands read).
  - Recognised opcodes (LOAD 0000011, STORE 0100011, OP_IMM 0010011, OP 0110011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111, MISC_MEM 0001111, SYSTEM 1110011): go to EXECUTE.
  - Any other opcode: illegal_inst=1, pc_write_enable=1, next_pc_select=0, go to FETCH.
- EXECUTE, by opcode:
  - LOAD/STORE: a=rs1, b=imm, ADD; go to MEM.
  - OP_IMM: a=rs1, b=imm, op 1; go to WRITEBACK.
  - OP: a=rs1, b=rs2, op 2; go to WRITEBACK.
  - AUIPC: a=PC, b=imm, ADD; go to WRITEBACK.
  - LUI/JAL/JALR: go to WRITEBACK.
  - BRANCH: a=rs1, b=rs2, op 3; pc_write_enable=1, next_pc_select = take_branch ? 1 : 0; go to FETCH.
  - MISC_MEM/SYSTEM: NOP; pc_write_enable=1, next_pc_select=0; go to FETCH.
- MEM: mem_address_select=1; mem_read_enable=1 for LOAD, mem_write_enable=1 for STORE. Request held stable until mem_ready=1.
  - STORE with mem_ready: pc_write_enable=1, next_pc_select=0, go to FETCH.
  - LOAD with mem_ready: go to WRITEBACK.
- WRITEBACK: regfile_write_enable=1 and pc_write_enable=1, both for exactly one cycle.
  - reg_writeback_select: LOAD=1, JAL/JALR=2, LUI=3, otherwise 0.
  - next_pc_select: JAL=2, JALR=3, otherwise 0.
  - Go to FETCH.
- Latency with mem_ready tied 1: branch/NOP 3 cycles; ALU, LUI, AUIPC, JAL, JALR and store 4 cycles; load 5 cycles. Each mem_ready=0 cycle adds one cycle.
- Exactly one pc_write_enable pulse per instruction. mem_read_enable and mem_write_enable are never asserted together.

Optional Feature:
RVSIMPLE_MC_PERF_COUNTERS_EN.
- Defined: adds outputs retired_count[31:0] and stall_count[31:0], both cleared by reset.
  - retired_count increments on every pc_write_enable pulse, including illegal instructions.
  - stall_count increments each cycle in FETCH or MEM with mem_ready=0.
  - Both wrap from 0xFFFFFFFF to 0.
- Undefined: ports and registers are absent; all other behaviour is identical.

Test Plan:
1. Reset held 3 cycles mid-EXECUTE of an OP -> all outputs 0 during reset, no regfile write; fsm_state=0 the cycle after release, with mem_read_enable=1.
2. ADD (opcode 0110011), mem_ready=1 -> states 0,1,2,4,0; alu_op_type=2 in EXECUTE; regfile_write_enable and pc_write_enable high only in cycle 4, with reg_writeback_select=0.
3. LW (0000011), memory stalls 2 cycles in MEM -> mem_read_enable and mem_address_select=1 held 3 cycles; WRITEBACK with reg_writeback_select=1; 7 cycles total.
4. BEQ (1100011), take_branch=1 then =0 on a second BEQ -> 3 cycles each, next_pc_select=1 then 0; no regfile write.
5. JALR (1100111) -> WRITEBACK with reg_writeback_select=2, next_pc_select=3; SW (0100011) -> mem_write_enable in MEM, no regfile write.
6. Opcode 1111111 -> illegal_inst pulse in DECODE, pc_write_enable=1, next_pc_select=0, back to FETCH. With the macro defined: retired_count=1 and stall_count unchanged.
